pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer for a small instruction fetch unit.
//                Walks the pc sequentially, honours jump / conditional branch
//                redirects, stalls without losing an address, halts and
//                restarts under control of run.  All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [7:0] PC_MAX   = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic       stall,
   input  logic       halt,
   input  logic       jump,
   input  logic       branch,
   input  logic       cond,
   input  logic [7:0] target,
   output logic [7:0] pc,
   output logic       pc_valid,
   output logic [1:0] state,
   output logic [7:0] fetch_count,
   output logic       wrap
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FETCH  = 2'b01,
      ST_STALL  = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   state_t     r_state;
   logic [7:0] r_pc;
   logic       r_pc_valid;
   logic [7:0] r_fetch_count;
   logic       r_wrap;

   logic [7:0] w_next_pc;
   logic       w_next_wrap;

   // Address to fetch after a FETCH cycle with no halt/stall: redirect or
   // sequential, folding anything past PC_MAX back to RESET_PC.
   always_comb begin
      w_next_pc   = r_pc + 8'd1;
      w_next_wrap = 1'b0;
      if (jump || (branch && cond)) begin
         if (target > PC_MAX) begin
            w_next_pc   = RESET_PC;
            w_next_wrap = 1'b1;
         end else begin
            w_next_pc   = target;
         end
      end else if (r_pc == PC_MAX) begin
         w_next_pc   = RESET_PC;
         w_next_wrap = 1'b1;
      end
   end

   // Sequencer state, pc and status flags; reset clears everything at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_pc_valid    <= 1'b0;
         r_fetch_count <= 8'h00;
         r_wrap        <= 1'b0;
      end else begin
         // Count cycles in which the presented pc was a live fetch.
         if (r_pc_valid && (r_fetch_count != 8'hFF)) begin
            r_fetch_count <= r_fetch_count + 8'd1;
         end

         case (r_state)
            ST_IDLE: begin
               r_pc <= RESET_PC;
               if (run) begin
                  r_state    <= ST_FETCH;
                  r_pc_valid <= 1'b1;
               end
            end

            ST_FETCH: begin
               if (halt) begin
                  r_state    <= ST_HALTED;
                  r_pc_valid <= 1'b0;
               end else if (stall) begin
                  // Current pc is held so it is re-presented on release.
                  r_state    <= ST_STALL;
                  r_pc_valid <= 1'b0;
               end else begin
                  r_pc   <= w_next_pc;
                  r_wrap <= r_wrap | w_next_wrap;
               end
            end

            ST_STALL: begin
               if (halt) begin
                  r_state <= ST_HALTED;
               end else if (!stall) begin
                  r_state    <= ST_FETCH;
                  r_pc_valid <= 1'b1;
               end
            end

            ST_HALTED: begin
               // A fresh rising run is needed to restart, so go via IDLE.
               if (!run) begin
                  r_state <= ST_IDLE;
                  r_pc    <= RESET_PC;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_pc       <= RESET_PC;
               r_pc_valid <= 1'b0;
            end
         endcase
      end
   end

   assign pc          = r_pc;
   assign pc_valid    = r_pc_valid;
   assign state       = r_state;
   assign fetch_count = r_fetch_count;
   assign wrap        = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Self-checking bench for pc_sequencer.  Two instances (full
//                8-bit range and PC_MAX=0F) share one stimulus stream and are
//                compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       reset, run, stall, halt, jump, branch, cond;
   logic [7:0] target;

   logic [7:0] pc_a, pc_b, fc_a, fc_b;
   logic       v_a, v_b, w_a, w_b;
   logic [1:0] st_a, st_b;

   int tests = 0;
   int fails = 0;

   // Behavioural model: one entry per instance.
   // Mode: 0 idle, 1 fetching, 2 stalled, 3 halted.
   int m_st[2], m_pc[2], m_valid[2], m_cnt[2], m_wrap[2];
   int pmax[2];

   // 100 MHz clock
   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(8'h00), .PC_MAX(8'hFF)) dut_a (
      .clk(clk), .reset(reset), .run(run), .stall(stall), .halt(halt),
      .jump(jump), .branch(branch), .cond(cond), .target(target),
      .pc(pc_a), .pc_valid(v_a), .state(st_a), .fetch_count(fc_a), .wrap(w_a)
   );

   pc_sequencer #(.RESET_PC(8'h00), .PC_MAX(8'h0F)) dut_b (
      .clk(clk), .reset(reset), .run(run), .stall(stall), .halt(halt),
      .jump(jump), .branch(branch), .cond(cond), .target(target),
      .pc(pc_b), .pc_valid(v_b), .state(st_b), .fetch_count(fc_b), .wrap(w_b)
   );

   task automatic cmp(input string tag, input int k, input logic [7:0] obs,
                      input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[inst %0d] observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_st[k] = 0; m_pc[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0;
      end
   endtask

   // One rising edge worth of behaviour, written from the functional rules.
   task automatic model_step(input int k);
      int nxt;
      if (m_valid[k] == 1 && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
      case (m_st[k])
         0: if (run) begin m_st[k] = 1; m_pc[k] = 0; m_valid[k] = 1; end
         1: begin
            if (halt) begin
               m_st[k] = 3; m_valid[k] = 0;
            end else if (stall) begin
               m_st[k] = 2; m_valid[k] = 0;
            end else begin
               nxt = (jump || (branch && cond)) ? int'(target) : m_pc[k] + 1;
               if (nxt > pmax[k]) begin nxt = 0; m_wrap[k] = 1; end
               m_pc[k] = nxt;
            end
         end
         2: begin
            if (halt) m_st[k] = 3;
            else if (!stall) begin m_st[k] = 1; m_valid[k] = 1; end
         end
         default: if (!run) begin m_st[k] = 0; m_pc[k] = 0; end
      endcase
   endtask

   task automatic check_all(input string tag);
      cmp({tag, "_pc"},    0, pc_a, 8'(m_pc[0]));
      cmp({tag, "_valid"}, 0, {7'd0, v_a}, 8'(m_valid[0]));
      cmp({tag, "_state"}, 0, {6'd0, st_a}, 8'(m_st[0]));
      cmp({tag, "_count"}, 0, fc_a, 8'(m_cnt[0]));
      cmp({tag, "_wrap"},  0, {7'd0, w_a}, 8'(m_wrap[0]));
      cmp({tag, "_pc"},    1, pc_b, 8'(m_pc[1]));
      cmp({tag, "_valid"}, 1, {7'd0, v_b}, 8'(m_valid[1]));
      cmp({tag, "_state"}, 1, {6'd0, st_b}, 8'(m_st[1]));
      cmp({tag, "_count"}, 1, fc_b, 8'(m_cnt[1]));
      cmp({tag, "_wrap"},  1, {7'd0, w_b}, 8'(m_wrap[1]));
   endtask

   // Advance one clock, update the model with the inputs held across the edge,
   // then check away from the edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      if (!reset) model_reset();
      else for (int k = 0; k < 2; k++) model_step(k);
      #1;
      check_all(tag);
   endtask

   task automatic quiet();
      run = 0; stall = 0; halt = 0; jump = 0; branch = 0; cond = 0; target = 8'h00;
   endtask

   initial begin
      pmax[0] = 255;
      pmax[1] = 15;
      reset = 1'b0;
      quiet();
      model_reset();
      #2;
      check_all("reset_init");
      cycle("reset_held");
      cycle("reset_held");
      reset = 1'b1;

      // Stay idle until run is seen, then fetch 00..03
      cycle("idle_wait");
      cmp("idle_state", 0, {6'd0, st_a}, 8'h00);
      run = 1;
      cycle("run_start");
      cmp("first_fetch_pc", 0, pc_a, 8'h00);
      cmp("first_fetch_valid", 0, {7'd0, v_a}, 8'h01);
      run = 0;
      repeat (4) cycle("seq");
      cmp("seq_count", 0, fc_a, 8'd4);
      cmp("seq_pc", 0, pc_a, 8'h04);

      // Sequential wrap on the PC_MAX=0F instance
      repeat (10) cycle("to_0e");
      cmp("b_pc_0e", 1, pc_b, 8'h0E);
      cmp("b_wrap_pre", 1, {7'd0, w_b}, 8'h00);
      cycle("to_0f");
      cmp("b_pc_0f", 1, pc_b, 8'h0F);
      cycle("wrap");
      cmp("b_pc_wrapped", 1, pc_b, 8'h00);
      cmp("b_wrap_set", 1, {7'd0, w_b}, 8'h01);
      cmp("a_no_wrap", 0, {7'd0, w_a}, 8'h00);
      jump = 1; target = 8'h40;
      cycle("jump_oor");
      cmp("a_jump_40", 0, pc_a, 8'h40);
      cmp("b_jump_oor", 1, pc_b, 8'h00);
      cmp("b_wrap_sticky", 1, {7'd0, w_b}, 8'h01);

      // Redirect priority
      target = 8'h05;
      cycle("jump_05");
      jump = 1; branch = 1; cond = 0; target = 8'h20;
      cycle("jump_wins");
      cmp("jump_wins_pc", 0, pc_a, 8'h20);
      jump = 0; branch = 1; cond = 0;
      cycle("branch_nt");
      cmp("branch_nt_pc", 0, pc_a, 8'h21);
      cond = 1; target = 8'h10;
      cycle("branch_t");
      cmp("branch_t_pc", 0, pc_a, 8'h10);

      // Stall window with a jump pulse inside it
      quiet(); jump = 1; target = 8'h07;
      cycle("jump_07");
      jump = 0; stall = 1;
      cycle("stall1");
      jump = 1; target = 8'h33;
      cycle("stall2");
      cmp("stall_pc", 0, pc_a, 8'h07);
      cmp("stall_valid", 0, {7'd0, v_a}, 8'h00);
      jump = 0;
      cycle("stall3");
      stall = 0;
      cycle("stall_release");
      cmp("release_pc", 0, pc_a, 8'h07);
      cmp("release_valid", 0, {7'd0, v_a}, 8'h01);
      cycle("after_release");
      cmp("after_release_pc", 0, pc_a, 8'h08);

      // Halt and restart protocol
      jump = 1; target = 8'h03;
      cycle("jump_03");
      jump = 0; halt = 1;
      cycle("halt");
      cmp("halt_state", 0, {6'd0, st_a}, 8'h03);
      cmp("halt_pc", 0, pc_a, 8'h03);
      halt = 0; run = 1;
      repeat (2) cycle("halt_run_high");
      cmp("halt_stays", 0, {6'd0, st_a}, 8'h03);
      run = 0;
      cycle("halt_to_idle");
      cmp("idle_again", 0, {6'd0, st_a}, 8'h00);
      run = 1;
      cycle("restart");
      cmp("restart_pc", 0, pc_a, 8'h00);
      run = 0;

      // Asynchronous reset between edges while fetching at 0A
      jump = 1; target = 8'h0A;
      cycle("jump_0a");
      jump = 0;
      #3;
      reset = 1'b0;
      #1;
      model_reset();
      check_all("async_reset");
      cmp("async_count", 0, fc_a, 8'h00);
      cycle("reset_low");
      reset = 1'b1;
      repeat (2) cycle("post_reset_idle");
      run = 1;
      cycle("post_reset_run");
      run = 0;

      // fetch_count saturation
      repeat (300) cycle("saturate");
      cmp("count_sat", 0, fc_a, 8'hFF);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         run    = ($urandom_range(0, 3) != 0);
         halt   = ($urandom_range(0, 19) == 0);
         stall  = ($urandom_range(0, 7) == 0);
         jump   = ($urandom_range(0, 7) == 0);
         branch = ($urandom_range(0, 3) == 0);
         cond   = $urandom_range(0, 1) == 1;
         target = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31))
                                              : 8'($urandom_range(0, 255));
         cycle("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
